// File: rtl/usb_pkg.sv
// Shared types for the USB host transaction path: packet payload, PIDs, FSM states.
package usb_pkg;

  localparam int unsigned PID_W  = 4;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned ENDP_W = 4;
  localparam int unsigned DATA_W = 64;

  localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
  localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
  localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
  localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
  localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;

  typedef struct packed {
    logic [PID_W-1:0]  pid;
    logic [ADDR_W-1:0] addr;
    logic [ENDP_W-1:0] endp;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_TOKEN,
    ST_SEND_DATA,
    ST_WAIT_HS,
    ST_WAIT_DATA,
    ST_SEND_HS,
    ST_FINISH
  } txn_state_t;

  typedef enum logic {
    DIR_OUT,
    DIR_IN
  } dir_t;

  function automatic pkt_t mk_pkt(input logic [PID_W-1:0]  pid,
                                  input logic [ADDR_W-1:0] addr,
                                  input logic [ENDP_W-1:0] endp,
                                  input logic [DATA_W-1:0] data);
    pkt_t p;
    p.pid  = pid;
    p.addr = addr;
    p.endp = endp;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Handshake/data wait timer: counts while enabled, saturates at TIMEOUT_CYCLES-1.
module usb_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  assign expired_c = (timer == LAST);

  // Holds at LAST so a long wait never wraps back into a fresh window
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && !expired_c) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host transaction sequencer: token / data / handshake with timeout and bounded retry.
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned       MAX_RETRY      = 8,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [ADDR_W-1:0] DEV_ADDR       = 7'd5,
  parameter logic [ENDP_W-1:0] DEV_ENDP       = 4'd4
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start_out,
  input  logic              start_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              txn_done,
  output logic              txn_ok,
  output logic [DATA_W-1:0] rd_data,
  output logic              tx_encode,
  output pkt_t              tx_pkt,
  input  logic              tx_done,
  output logic              rx_decode,
  input  pkt_t              rx_pkt,
  input  logic              rx_done,
  input  logic              rx_err
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  txn_state_t        state, state_nxt;
  dir_t              dir, dir_nxt;
  logic [DATA_W-1:0] payload, payload_nxt;
  logic [PID_W-1:0]  hs, hs_nxt;
  logic [RW-1:0]     retry_cnt, retry_nxt;
  logic              busy_nxt, txn_done_nxt, txn_ok_nxt, tx_encode_nxt, rx_decode_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  pkt_t              tx_pkt_nxt;
  logic              success, attempt_fail;
  logic              in_wait, expired_c;
  logic              unused_rx_bits;

  assign in_wait        = (state == ST_WAIT_HS) || (state == ST_WAIT_DATA);
  assign unused_rx_bits = ^{rx_pkt.addr, rx_pkt.endp};

  usb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_L    (rst_L),
    .clear    (!in_wait),
    .enable   (in_wait),
    .expired_c(expired_c)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= ST_IDLE;
      dir       <= DIR_OUT;
      payload   <= '0;
      hs        <= '0;
      retry_cnt <= '0;
      busy      <= 1'b0;
      txn_done  <= 1'b0;
      txn_ok    <= 1'b0;
      rd_data   <= '0;
      tx_encode <= 1'b0;
      tx_pkt    <= '0;
      rx_decode <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      payload   <= payload_nxt;
      hs        <= hs_nxt;
      retry_cnt <= retry_nxt;
      busy      <= busy_nxt;
      txn_done  <= txn_done_nxt;
      txn_ok    <= txn_ok_nxt;
      rd_data   <= rd_data_nxt;
      tx_encode <= tx_encode_nxt;
      tx_pkt    <= tx_pkt_nxt;
      rx_decode <= rx_decode_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dir_nxt       = dir;
    payload_nxt   = payload;
    hs_nxt        = hs;
    retry_nxt     = retry_cnt;
    busy_nxt      = busy;
    txn_done_nxt  = 1'b0;
    txn_ok_nxt    = txn_ok;
    rd_data_nxt   = rd_data;
    tx_encode_nxt = 1'b0;
    tx_pkt_nxt    = tx_pkt;
    rx_decode_nxt = 1'b0;
    success       = 1'b0;
    attempt_fail  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_out || start_in) begin
          dir_nxt = start_out ? DIR_OUT : DIR_IN;
          if (start_out) begin
            payload_nxt = wr_data;
          end
          retry_nxt = RW'(1);
          busy_nxt  = 1'b1;
          state_nxt = ST_SEND_TOKEN;
        end
      end
      ST_SEND_TOKEN: begin
        if (tx_done) begin
          state_nxt = (dir == DIR_OUT) ? ST_SEND_DATA : ST_WAIT_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (tx_done) begin
          state_nxt = ST_WAIT_HS;
        end
      end
      ST_WAIT_HS: begin
        // A packet arriving on the expiry cycle still counts
        if (rx_done) begin
          if (!rx_err && (rx_pkt.pid == PID_ACK)) begin
            success = 1'b1;
          end else begin
            attempt_fail = 1'b1;
          end
        end else if (expired_c) begin
          attempt_fail = 1'b1;
        end
      end
      ST_WAIT_DATA: begin
        if (rx_done) begin
          if (rx_err) begin
            hs_nxt    = PID_NAK;
            state_nxt = ST_SEND_HS;
          end else if (rx_pkt.pid == PID_DATA0) begin
            rd_data_nxt = rx_pkt.data;
            hs_nxt      = PID_ACK;
            state_nxt   = ST_SEND_HS;
          end else begin
            attempt_fail = 1'b1;
          end
        end else if (expired_c) begin
          attempt_fail = 1'b1;
        end
      end
      ST_SEND_HS: begin
        if (tx_done) begin
          if (hs == PID_ACK) begin
            success = 1'b1;
          end else begin
            attempt_fail = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (success) begin
      state_nxt    = ST_FINISH;
      txn_done_nxt = 1'b1;
      txn_ok_nxt   = 1'b1;
    end else if (attempt_fail) begin
      if (retry_cnt == RW'(MAX_RETRY)) begin
        state_nxt    = ST_FINISH;
        txn_done_nxt = 1'b1;
        txn_ok_nxt   = 1'b0;
      end else begin
        retry_nxt = retry_cnt + RW'(1);
        state_nxt = ST_SEND_TOKEN;
      end
    end

    // Launch a packet on entry to any SEND state; tx_pkt then holds until the next launch
    if (state_nxt != state) begin
      case (state_nxt)
        ST_SEND_TOKEN: begin
          tx_encode_nxt = 1'b1;
          tx_pkt_nxt    = mk_pkt((dir_nxt == DIR_OUT) ? PID_OUT : PID_IN,
                                 DEV_ADDR, DEV_ENDP, '0);
        end
        ST_SEND_DATA: begin
          tx_encode_nxt = 1'b1;
          tx_pkt_nxt    = mk_pkt(PID_DATA0, '0, '0, payload);
        end
        ST_SEND_HS: begin
          tx_encode_nxt = 1'b1;
          tx_pkt_nxt    = mk_pkt(hs_nxt, '0, '0, '0);
        end
        default: ;
      endcase
    end

    rx_decode_nxt = (state_nxt == ST_WAIT_HS) || (state_nxt == ST_WAIT_DATA);
  end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl: bench plays tx/rx engines, scoreboards tx packets and completions.
module tb_usb_txn_ctrl;
  import usb_pkg::*;

  localparam logic [3:0] E_OUT   = 4'b0001;
  localparam logic [3:0] E_IN    = 4'b1001;
  localparam logic [3:0] E_DATA0 = 4'b0011;
  localparam logic [3:0] E_ACK   = 4'b0010;
  localparam logic [3:0] E_NAK   = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        start_out = 1'b0;
  logic        start_in = 1'b0;
  logic [63:0] wr_data = '0;
  logic        busy, txn_done, txn_ok, tx_encode, rx_decode;
  logic [63:0] rd_data;
  pkt_t        tx_pkt;
  logic        tx_done = 1'b0;
  pkt_t        rx_pkt = '0;
  logic        rx_done = 1'b0;
  logic        rx_err = 1'b0;

  usb_txn_ctrl dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .start_out(start_out),
    .start_in (start_in),
    .wr_data  (wr_data),
    .busy     (busy),
    .txn_done (txn_done),
    .txn_ok   (txn_ok),
    .rd_data  (rd_data),
    .tx_encode(tx_encode),
    .tx_pkt   (tx_pkt),
    .tx_done  (tx_done),
    .rx_decode(rx_decode),
    .rx_pkt   (rx_pkt),
    .rx_done  (rx_done),
    .rx_err   (rx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic        chk_rd;
    logic [63:0] rd;
  } done_t;

  int    tests = 0;
  int    fails = 0;
  int    enc_cnt = 0;
  int    done_cnt = 0;
  pkt_t  tx_q[$];
  done_t done_q[$];

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t tok(input logic is_out);
    pkt_t p;
    p.pid  = is_out ? E_OUT : E_IN;
    p.addr = 7'd5;
    p.endp = 4'd4;
    p.data = '0;
    return p;
  endfunction

  function automatic pkt_t dpkt(input logic [3:0] pid, input logic [63:0] d);
    pkt_t p;
    p.pid  = pid;
    p.addr = '0;
    p.endp = '0;
    p.data = d;
    return p;
  endfunction

  // Monitors: every launch is checked against the expected tx stream, every completion against done_q
  always @(negedge clk) begin
    if (rst_L && tx_encode) begin
      enc_cnt++;
      if (tx_q.size() == 0) chk("tx_unexpected", 79'(tx_q.size()), 79'(1));
      else chk("tx_pkt", tx_pkt, tx_q.pop_front());
    end
    if (rst_L && txn_done) begin
      done_t e;
      done_cnt++;
      if (done_q.size() == 0) begin
        chk("done_unexpected", 79'(done_q.size()), 79'(1));
      end else begin
        e = done_q.pop_front();
        chk("txn_ok", 79'(txn_ok), 79'(e.ok));
        if (e.chk_rd) chk("rd_data", 79'(rd_data), 79'(e.rd));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic is_out, input logic [63:0] d);
    wr_data = d;
    if (is_out) start_out = 1'b1;
    else start_in = 1'b1;
    tick();
    start_out = 1'b0;
    start_in  = 1'b0;
    wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("busy_after_start", 79'(busy), 79'(1));
  endtask

  task automatic serve_tx(input string tag);
    int n = 0;
    while (!tx_encode && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_launch"}, 79'(tx_encode), 79'(1));
    if (tx_encode) begin
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (!rx_decode && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_rx_armed"}, 79'(rx_decode), 79'(1));
  endtask

  task automatic rx_reply(input string tag, input logic [3:0] pid, input logic [63:0] d,
                          input logic err);
    wait_rx(tag);
    tick();
    tick();
    rx_pkt  = dpkt(pid, d);
    rx_err  = err;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    rx_pkt  = '0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n = 0;
    while (done_cnt == base && n < 5000) begin
      tick();
      n++;
    end
    chk({tag, "_done_count"}, 79'(done_cnt - base), 79'(1));
  endtask

  initial begin
    int    e0, d0, cnt;
    done_t de;

    tick();
    tick();
    chk("rst_busy", 79'(busy), 79'(0));
    chk("rst_txn_done", 79'(txn_done), 79'(0));
    chk("rst_txn_ok", 79'(txn_ok), 79'(0));
    chk("rst_rd_data", 79'(rd_data), 79'(0));
    chk("rst_tx_encode", 79'(tx_encode), 79'(0));
    chk("rst_tx_pkt", tx_pkt, 79'(0));
    chk("rst_rx_decode", 79'(rx_decode), 79'(0));
    rst_L = 1'b1;
    tick();

    // OUT, immediate ACK
    e0 = enc_cnt; d0 = done_cnt;
    tx_q.push_back(tok(1'b1));
    tx_q.push_back(dpkt(E_DATA0, 64'hDEADBEEF_CAFEF00D));
    de = '{ok: 1'b1, chk_rd: 1'b0, rd: 64'd0}; done_q.push_back(de);
    start(1'b1, 64'hDEADBEEF_CAFEF00D);
    serve_tx("t1_tok");
    serve_tx("t1_data");
    rx_reply("t1", E_ACK, 64'd0, 1'b0);
    chk("t1_done_latency", 79'(txn_done), 79'(1));
    wait_done("t1", d0);
    chk("t1_encodes", 79'(enc_cnt - e0), 79'(2));
    tick();
    chk("t1_busy_clear", 79'(busy), 79'(0));

    // OUT, NAK NAK ACK
    e0 = enc_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(tok(1'b1));
      tx_q.push_back(dpkt(E_DATA0, 64'h1111_2222_3333_4444));
    end
    de = '{ok: 1'b1, chk_rd: 1'b0, rd: 64'd0}; done_q.push_back(de);
    start(1'b1, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 3; i++) begin
      serve_tx("t2_tok");
      serve_tx("t2_data");
      rx_reply("t2", (i < 2) ? E_NAK : E_ACK, 64'd0, 1'b0);
    end
    wait_done("t2", d0);
    chk("t2_encodes", 79'(enc_cnt - e0), 79'(6));

    // IN, clean DATA0
    e0 = enc_cnt; d0 = done_cnt;
    tx_q.push_back(tok(1'b0));
    tx_q.push_back(dpkt(E_ACK, 64'd0));
    de = '{ok: 1'b1, chk_rd: 1'b1, rd: 64'h0123_4567_89AB_CDEF}; done_q.push_back(de);
    start(1'b0, 64'd0);
    serve_tx("t3_tok");
    rx_reply("t3", E_DATA0, 64'h0123_4567_89AB_CDEF, 1'b0);
    serve_tx("t3_ack");
    chk("t3_done_latency", 79'(txn_done), 79'(1));
    wait_done("t3", d0);
    chk("t3_encodes", 79'(enc_cnt - e0), 79'(2));

    // IN, corrupted DATA0 then clean
    e0 = enc_cnt; d0 = done_cnt;
    tx_q.push_back(tok(1'b0));
    tx_q.push_back(dpkt(E_NAK, 64'd0));
    tx_q.push_back(tok(1'b0));
    tx_q.push_back(dpkt(E_ACK, 64'd0));
    de = '{ok: 1'b1, chk_rd: 1'b1, rd: 64'hA5A5_5A5A_0F0F_F0F0}; done_q.push_back(de);
    start(1'b0, 64'd0);
    serve_tx("t4_tok1");
    rx_reply("t4_bad", E_DATA0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
    serve_tx("t4_nak");
    serve_tx("t4_tok2");
    rx_reply("t4_good", E_DATA0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    serve_tx("t4_ack");
    wait_done("t4", d0);
    chk("t4_encodes", 79'(enc_cnt - e0), 79'(4));

    // OUT, silent device: eight 255-cycle waits, then failure; rd_data untouched
    e0 = enc_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(tok(1'b1));
      tx_q.push_back(dpkt(E_DATA0, 64'h5555_6666_7777_8888));
    end
    de = '{ok: 1'b0, chk_rd: 1'b1, rd: 64'hA5A5_5A5A_0F0F_F0F0}; done_q.push_back(de);
    start(1'b1, 64'h5555_6666_7777_8888);
    for (int a = 0; a < 8; a++) begin
      serve_tx("t5_tok");
      serve_tx("t5_data");
      wait_rx("t5");
      cnt = 0;
      while (rx_decode && cnt < 1000) begin
        start_in = (a == 0 && cnt == 10);
        tick();
        cnt++;
      end
      start_in = 1'b0;
      chk("t5_wait_len", 79'(cnt), 79'(255));
    end
    wait_done("t5", d0);
    chk("t5_encodes", 79'(enc_cnt - e0), 79'(16));

    // Reset while waiting for the handshake
    d0 = done_cnt;
    tx_q.push_back(tok(1'b1));
    tx_q.push_back(dpkt(E_DATA0, 64'h9999_AAAA_BBBB_CCCC));
    start(1'b1, 64'h9999_AAAA_BBBB_CCCC);
    serve_tx("t6_tok");
    serve_tx("t6_data");
    wait_rx("t6");
    tick();
    tick();
    tick();
    #2 rst_L = 1'b0;
    #1;
    chk("t6_busy", 79'(busy), 79'(0));
    chk("t6_tx_encode", 79'(tx_encode), 79'(0));
    chk("t6_rx_decode", 79'(rx_decode), 79'(0));
    chk("t6_txn_done", 79'(txn_done), 79'(0));
    tick();
    tick();
    rst_L = 1'b1;
    tick();
    tick();
    chk("t6_no_done", 79'(done_cnt - d0), 79'(0));
    chk("t6_tx_q_drained", 79'(tx_q.size()), 79'(0));

    // Normal OUT after reset
    e0 = enc_cnt; d0 = done_cnt;
    tx_q.push_back(tok(1'b1));
    tx_q.push_back(dpkt(E_DATA0, 64'h0F1E_2D3C_4B5A_6978));
    de = '{ok: 1'b1, chk_rd: 1'b0, rd: 64'd0}; done_q.push_back(de);
    start(1'b1, 64'h0F1E_2D3C_4B5A_6978);
    serve_tx("t7_tok");
    serve_tx("t7_data");
    rx_reply("t7", E_ACK, 64'd0, 1'b0);
    wait_done("t7", d0);
    chk("t7_encodes", 79'(enc_cnt - e0), 79'(2));
    tick();
    chk("end_tx_q_empty", 79'(tx_q.size()), 79'(0));
    chk("end_done_q_empty", 79'(done_q.size()), 79'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_txn_ctrl.md
Name: usb_txn_ctrl

Overview:
Host-side transaction sequencer for the USB serial transmit path (dataStream_out) and its receive counterpart.
- Turns a single OUT (write) or IN (read) request into the full packet sequence: token, data, handshake.
- Runs the handshake timeout and retry loop, then reports one completion status to the upper layer.
- Sits between the host register layer and the tx/rx serial engines.

Parameters:
- MAX_RETRY, 8: total attempts allowed per transaction, including the first attempt.
- TIMEOUT_CYCLES, 255: clk cycles to wait for rx_done before an attempt is declared timed out.
- DEV_ADDR, 7'd5: address field placed in every token.
- DEV_ENDP, 4'd4: endpoint field placed in every token.

Ports:
- clk  in  1  clock
- rst_L  in  1  asynchronous reset, active low
- start_out  in  1  one-cycle request for an OUT transaction
- start_in  in  1  one-cycle request for an IN transaction
- wr_data  in  64  OUT payload, sampled when start_out is accepted
- busy  out  1  high from start acceptance until txn_done
- txn_done  out  1  one-cycle completion pulse
- txn_ok  out  1  status, valid with txn_done; 1 = success
- rd_data  out  64  IN payload; valid with txn_done when txn_ok=1
- tx_encode  out  1  one-cycle launch pulse to the tx engine
- tx_pkt  out  pkt_t  packet to transmit; held stable from launch until tx_done
- tx_done  in  1  tx engine finished the packet, EOP sent
- rx_decode  out  1  level; receiver armed while in a WAIT state
- rx_pkt  in  pkt_t  received packet; valid with rx_done
- rx_done  in  1  one-cycle pulse, packet received
- rx_err  in  1  valid with rx_done; CRC, PID, stuffing or EOP error

Behaviour:
Reset values: busy=0, txn_done=0, txn_ok=0, rd_data=0, tx_encode=0, tx_pkt=0, rx_decode=0, state=IDLE, retry_cnt=0, timer=0.

Reset mid-operation:
- Abandons the transaction immediately. No txn_done is issued.
- tx_encode is forced to 0.

State machine: IDLE, SEND_TOKEN, SEND_DATA, WAIT_HS, WAIT_DATA, SEND_HS, FINISH.

IDLE:
- start_out: latch wr_data, set dir=OUT. Takes priority if start_in and start_out are both high.
- start_in: set dir=IN.
- Either start: retry_cnt<=1, busy<=1, go to SEND_TOKEN.
- Starts are ignored whenever busy=1.

SEND_TOKEN:
- tx_encode pulses on the first cycle in the state.
- tx_pkt = {pid OUT or IN, DEV_ADDR, DEV_ENDP}.
- Waits for tx_done, then goes to SEND_DATA (OUT) or WAIT_DATA (IN).

SEND_DATA (OUT only):
- tx_encode pulses; tx_pkt = {DATA0, latched payload}.
- Waits for tx_done, then goes to WAIT_HS.

WAIT_HS:
- rx_decode=1. Timer clears on entry and increments each cycle.
- rx_done with !rx_err and pid=ACK: success, go to FINISH.
- rx_done with pid=NAK, rx_err, any other pid, or timer==TIMEOUT_CYCLES-1 without rx_done: attempt fails.
- rx_done in the same cycle as timer expiry: rx_done wins.

WAIT_DATA:
- rx_decode=1, timer handled as in WAIT_HS.
- rx_done with !rx_err and pid=DATA0: capture rd_data, set hs=ACK, go to SEND_HS.
- rx_done with rx_err: hs=NAK, go to SEND_HS, then the attempt fails.
- rx_done with pid=NAK: attempt fails.
- Timeout: attempt fails, no handshake is sent.

SEND_HS:
- tx_encode pulses; tx_pkt = {hs}.
- On tx_done: FINISH (success) if hs=ACK, otherwise attempt fails.

Attempt failure:
- retry_cnt==MAX_RETRY: go to FINISH with failure.
- Otherwise: retry_cnt++, return to SEND_TOKEN, resending the token.

FINISH:
- txn_done=1 for one cycle, txn_ok=status, busy<=0, go to IDLE.
- rd_data holds until the next IN success.

Widths and limits:
- retry_cnt is $clog2(MAX_RETRY+1) bits.
- timer is $clog2(TIMEOUT_CYCLES) bits and never wraps: it stops at expiry.
- An unexpected rx_done outside a WAIT state is ignored.

Latency, best case:
- OUT: txn_done 1 cycle after the rx_done carrying ACK.
- IN: txn_done 1 cycle after the ACK's tx_done.

Decomposition:
- usb_pkg (shared):
  - pkt_t {pid[3:0], addr[6:0], endp[3:0], data[63:0]}
  - PID constants OUT/IN/DATA0/ACK/NAK
  - txn state enum
- usb_timeout_timer sub-module: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES.
- Everything else lives in usb_txn_ctrl.

Test Plan:
- OUT, wr_data=64'hDEADBEEF_CAFEF00D, bench replies ACK -> tx sequence OUT then DATA0 with that payload; txn_done with txn_ok=1; exactly 2 tx_encode pulses.
- OUT, bench replies NAK, NAK, ACK -> 3 OUT+DATA0 pairs (6 tx_encode pulses); txn_ok=1.
- IN, bench returns DATA0 with data=64'h0123_4567_89AB_CDEF -> ACK transmitted; rd_data matches; txn_ok=1.
- IN, first DATA0 has rx_err=1, second is clean -> NAK sent, then IN resent, then ACK; txn_ok=1.
- OUT, bench never responds -> each wait lasts exactly 255 cycles; txn_done with txn_ok=0 after 8 attempts; start_in asserted during busy has no effect.
- rst_L low during WAIT_HS -> busy=0, tx_encode=0, rx_decode=0 immediately; no txn_done; a new start_out after reset works normally.
